// File: rtl/feature_aggregator_pkg.sv
// Shared types and sizing helpers for the feature aggregator.
package feature_aggregator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    AGG,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_PVADD      = 256;
  localparam int unsigned DEFAULT_ROW_WIDTH  = DEFAULT_DATA_WIDTH * DEFAULT_PVADD;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned row_width(input int unsigned data_width,
                                            input int unsigned lanes);
    return data_width * lanes;
  endfunction

endpackage

// File: rtl/feature_aggregator_lane_adder.sv
// Lane-wise wrapping adder with an output register; idle cycles register zero.
module feature_aggregator_lane_adder
  import feature_aggregator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PVADD      = 256,
  localparam int unsigned RW        = row_width(DATA_WIDTH, PVADD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [RW-1:0] a,
  input  logic [RW-1:0] b,
  output logic [RW-1:0] sum
);

  logic [RW-1:0] sum_c;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(PVADD); i++) begin
      sum_c[i*DATA_WIDTH +: DATA_WIDTH] = a[i*DATA_WIDTH +: DATA_WIDTH] + b[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum <= '0;
    end else begin
      sum <= en ? sum_c : '0;
    end
  end

endmodule

// File: rtl/feature_aggregator.sv
// Clears bank-B accumulator rows, then accumulates bank-A source rows into
// bank-B destination rows for a stream of edges, stalling on RAW hazards.
module feature_aggregator
  import feature_aggregator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PVADD      = 256,
  parameter int unsigned K          = 1024,
  parameter int unsigned RD_LAT     = 2,
  localparam int unsigned AW        = addr_width(K),
  localparam int unsigned RW        = row_width(DATA_WIDTH, PVADD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   num_rows,
  output logic          busy,
  output logic          done,
  input  logic          edge_valid,
  output logic          edge_ready,
  input  logic [AW-1:0] edge_src,
  input  logic [AW-1:0] edge_dst,
  input  logic          edge_last,
  output logic [AW-1:0] addr_a1,
  input  logic [RW-1:0] rd_a1,
  output logic [AW-1:0] addr_b1,
  input  logic [RW-1:0] rd_b1,
  output logic [AW-1:0] addr_b2,
  output logic [RW-1:0] wr_b2,
  output logic          we_b2
);

  localparam int unsigned DEPTH   = RD_LAT + 1;
  localparam logic [AW:0] ONE_ROW = (AW+1)'(1);

  state_t          state, state_n;
  logic [AW:0]     nrows;
  logic [AW-1:0]   clear_last;
  logic [RD_LAT:0] tag_valid;
  logic [AW-1:0]   tag_dst [DEPTH];
  logic            accept, hazard;
  logic            busy_n, done_n, we_n;
  logic [AW-1:0]   addr_b2_n;

  assign clear_last = AW'(nrows - ONE_ROW);

  // State, dst tag pipeline and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      nrows     <= '0;
      tag_valid <= '0;
      for (int i = 0; i < int'(DEPTH); i++) tag_dst[i] <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      we_b2     <= 1'b0;
      addr_b2   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) nrows <= num_rows;
      tag_valid  <= {tag_valid[RD_LAT-1:0], accept};
      tag_dst[0] <= edge_dst;
      for (int i = 1; i < int'(DEPTH); i++) tag_dst[i] <= tag_dst[i-1];
      busy    <= busy_n;
      done    <= done_n;
      we_b2   <= we_n;
      addr_b2 <= addr_b2_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CLEAR;
      CLEAR:   if (addr_b2 == clear_last) state_n = AGG;
      AGG:     if (accept && edge_last) state_n = DRAIN;
      DRAIN:   if (tag_valid == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (tag_valid[i] && (tag_dst[i] == edge_dst)) hazard = 1'b1;
    end
    hazard     = hazard && edge_valid;
    edge_ready = (state == AGG) && !hazard;
    accept     = edge_valid && edge_ready;
    addr_a1    = accept ? edge_src : '0;
    addr_b1    = accept ? edge_dst : '0;

    busy_n = (state == IDLE) ? start : (state != DONE);
    done_n = (state == DRAIN) && (tag_valid == '0);

    // Clear writes take priority; no edge is in flight while clearing
    we_n      = 1'b0;
    addr_b2_n = '0;
    if (state == IDLE && start) begin
      we_n = 1'b1;
    end else if (state == CLEAR && addr_b2 != clear_last) begin
      we_n      = 1'b1;
      addr_b2_n = addr_b2 + AW'(1);
    end else if (tag_valid[RD_LAT-1]) begin
      we_n      = 1'b1;
      addr_b2_n = tag_dst[RD_LAT-1];
    end
  end

  feature_aggregator_lane_adder #(
    .DATA_WIDTH (DATA_WIDTH),
    .PVADD      (PVADD)
  ) u_lane_adder (
    .clk (clk),
    .rst (rst),
    .en  (tag_valid[RD_LAT-1]),
    .a   (rd_a1),
    .b   (rd_b1),
    .sum (wr_b2)
  );

endmodule

// File: tb/tb_feature_aggregator.sv
// Scoreboard bench for feature_aggregator with a behavioural dual-bank row RAM.
module tb_feature_aggregator;

  localparam int unsigned DW = 8;
  localparam int unsigned PV = 4;
  localparam int unsigned KR = 16;
  localparam int unsigned RD = 2;
  localparam int unsigned AW = 4;
  localparam int unsigned RW = 32;

  logic          clk, rst, start, busy, done;
  logic [AW:0]   num_rows;
  logic          edge_valid, edge_ready, edge_last, we_b2;
  logic [AW-1:0] edge_src, edge_dst, addr_a1, addr_b1, addr_b2;
  logic [RW-1:0] rd_a1, rd_b1, wr_b2;

  feature_aggregator #(
    .DATA_WIDTH (DW),
    .PVADD      (PV),
    .K          (KR),
    .RD_LAT     (RD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_rows   (num_rows),
    .busy       (busy),
    .done       (done),
    .edge_valid (edge_valid),
    .edge_ready (edge_ready),
    .edge_src   (edge_src),
    .edge_dst   (edge_dst),
    .edge_last  (edge_last),
    .addr_a1    (addr_a1),
    .rd_a1      (rd_a1),
    .addr_b1    (addr_b1),
    .rd_b1      (rd_b1),
    .addr_b2    (addr_b2),
    .wr_b2      (wr_b2),
    .we_b2      (we_b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row RAM model: registered read with RD cycles of latency, write on we_b2
  logic [RW-1:0] mem_a  [KR];
  logic [RW-1:0] mem_b  [KR];
  logic [RW-1:0] a_pipe [RD];
  logic [RW-1:0] b_pipe [RD];
  assign rd_a1 = a_pipe[RD-1];
  assign rd_b1 = b_pipe[RD-1];

  always @(posedge clk) begin
    if (we_b2) mem_b[addr_b2] <= wr_b2;
    a_pipe[0] <= mem_a[addr_a1];
    b_pipe[0] <= mem_b[addr_b1];
    for (int i = 1; i < int'(RD); i++) begin
      a_pipe[i] <= a_pipe[i-1];
      b_pipe[i] <= b_pipe[i-1];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   last_acc = 0;
  int   s;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Monitor: every bank-B write must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst && we_b2) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", addr_b2, wr_b2);
      end else begin
        e = sb.pop_front();
        check("write_addr", 64'(addr_b2), 64'(e.addr));
        check("write_data", 64'(wr_b2), 64'(e.data));
        check("write_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic do_start(input int n, input bit poke);
    int st;
    bit seen;
    @(posedge clk); #1;
    start    = 1'b1;
    num_rows = 5'(n);
    st       = cyc;
    for (int i = 0; i < n; i++) sb.push_back('{addr: AW'(i), data: RW'(0), cyc: st + 1 + i});
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) begin
      @(posedge clk); #1;
      start    = 1'b1;
      num_rows = 5'd2;
      @(posedge clk); #1;
      start = 1'b0;
    end
    seen = 1'b0;
    for (int w = 0; w < 200 && !seen; w++) begin
      @(negedge clk);
      if (edge_ready) seen = 1'b1;
    end
    if (!seen) fail_now("ready_after_clear");
    else check("ready_after_clear", 64'(cyc), 64'(st + 1 + n));
    @(posedge clk); #1;
  endtask

  task automatic send_edge(input int src, input int dst, input bit last,
                           input logic [RW-1:0] data, output int stalls);
    bit got;
    edge_valid = 1'b1;
    edge_src   = AW'(src);
    edge_dst   = AW'(dst);
    edge_last  = last;
    stalls     = 0;
    got        = 1'b0;
    for (int w = 0; w < 50 && !got; w++) begin
      @(negedge clk);
      if (edge_ready) begin
        got      = 1'b1;
        last_acc = cyc;
        sb.push_back('{addr: AW'(dst), data: data, cyc: cyc + RD + 1});
      end else begin
        stalls++;
      end
    end
    if (!got) fail_now("edge_accept");
    @(posedge clk); #1;
    if (last) edge_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_cyc);
    bit seen;
    seen = 1'b0;
    for (int w = 0; w < 200 && !seen; w++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      fail_now("done");
    end else begin
      check("done_cycle", 64'(cyc), 64'(exp_cyc));
      check("busy_at_done", 64'(busy), 64'd1);
      @(negedge clk);
      check("done_pulse", 64'(done), 64'd0);
      check("busy_after_done", 64'(busy), 64'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(KR); i++) begin
      mem_a[i] = '0;
      mem_b[i] = 32'hDEADBEEF;
    end
    for (int i = 0; i < int'(RD); i++) begin
      a_pipe[i] = '0;
      b_pipe[i] = '0;
    end
    mem_a[0] = 32'hFFFFFFFF;
    mem_a[1] = 32'h05060708;
    mem_a[2] = 32'h0A0B0C0D;
    mem_a[3] = 32'h01020304;
    mem_a[4] = 32'h0A0A0A0A;

    rst = 1'b0; start = 1'b0; num_rows = '0;
    edge_valid = 1'b0; edge_src = '0; edge_dst = '0; edge_last = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_ready", 64'(edge_ready), 64'd0);
    check("reset_we", 64'(we_b2), 64'd0);
    check("reset_addr_b2", 64'(addr_b2), 64'd0);
    check("reset_wr_b2", 64'(wr_b2), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Full clear, then a single edge
    do_start(16, 1'b0);
    send_edge(3, 5, 1'b1, 32'h01020304, s);
    check("stall_single", 64'(s), 64'd0);
    wait_done(last_acc + RD + 3);

    // Back-to-back distinct destinations; a start during CLEAR is ignored
    do_start(16, 1'b1);
    send_edge(0, 1, 1'b0, 32'hFFFFFFFF, s);
    check("stall_b2b_0", 64'(s), 64'd0);
    send_edge(1, 2, 1'b0, 32'h05060708, s);
    check("stall_b2b_1", 64'(s), 64'd0);
    send_edge(2, 3, 1'b1, 32'h0A0B0C0D, s);
    check("stall_b2b_2", 64'(s), 64'd0);
    wait_done(last_acc + RD + 3);

    // RAW hazard on the same destination
    do_start(16, 1'b0);
    send_edge(3, 5, 1'b0, 32'h01020304, s);
    send_edge(4, 5, 1'b1, 32'h0B0C0D0E, s);
    check("stall_hazard", 64'(s), 64'd3);
    wait_done(last_acc + RD + 3);

    // Lane wraparound: 0xFF + 0xFF = 0xFE
    do_start(16, 1'b0);
    send_edge(0, 0, 1'b0, 32'hFFFFFFFF, s);
    send_edge(0, 0, 1'b1, 32'hFEFEFEFE, s);
    check("stall_wrap", 64'(s), 64'd3);
    wait_done(last_acc + RD + 3);

    // Single-row clear
    do_start(1, 1'b0);
    send_edge(2, 0, 1'b1, 32'h0A0B0C0D, s);
    wait_done(last_acc + RD + 3);

    // Async reset with two edges in flight
    do_start(4, 1'b0);
    send_edge(1, 2, 1'b0, 32'h05060708, s);
    send_edge(2, 3, 1'b0, 32'h0A0B0C0D, s);
    rst = 1'b0;
    edge_valid = 1'b0;
    #1;
    sb.delete();
    check("abort_we", 64'(we_b2), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(edge_ready), 64'd0);
    check("abort_addr_a1", 64'(addr_a1), 64'd0);
    check("abort_addr_b2", 64'(addr_b2), 64'd0);
    check("abort_wr_b2", 64'(wr_b2), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("busy_after_release", 64'(busy), 64'd0);
    do_start(4, 1'b0);
    send_edge(3, 3, 1'b1, 32'h01020304, s);
    wait_done(last_acc + RD + 3);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
